// File: rtl/delta_demod.sv
// Delta-stream demodulator: saturating 8-bit integrator plus boxcar decimator with a valid/ready output.
// Optional slope-overload detector is compiled in with `define DELTA_DEMOD_OVLD_EN.
module delta_demod #(
    parameter int LOG2_DEC = 2,
    parameter int OVLD_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_en,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] integ,
    output logic       overrun,
    input  logic       clr_overrun,
    output logic       ovld
);

    localparam int AW = 8 + LOG2_DEC;
    localparam int CW = LOG2_DEC;

    if (LOG2_DEC < 1 || LOG2_DEC > 6 || OVLD_LEN < 2 || OVLD_LEN > 255) begin : g_bad_params
        $error("delta_demod: parameter out of range");
    end

    logic [7:0]    integ_q, integ_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          overrun_q, overrun_d;
    logic [AW-1:0] sum;
    logic          sample_done;

    // Handshake: a sample is consumed on any posedge where out_valid and out_ready are
    // both high; out_data never changes while valid unless a newer sample replaces it.
    always_comb begin
        integ_d = integ_q;
        if (bit_en) begin
            if (bit_in && integ_q != 8'hFF)
                integ_d = integ_q + 8'd1;
            else if (!bit_in && integ_q != 8'h00)
                integ_d = integ_q - 8'd1;
        end
    end

    always_comb begin
        sum         = acc_q + {{LOG2_DEC{1'b0}}, integ_d};
        sample_done = bit_en && (cnt_q == {CW{1'b1}});
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        if (bit_en) begin
            if (sample_done) begin
                acc_d      = '0;
                cnt_d      = '0;
                out_data_d = sum[AW-1 -: 8];
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        out_valid_d = sample_done || (out_valid_q && !out_ready);
        // Set has priority over a clear arriving on the same edge.
        overrun_d   = (sample_done && out_valid_q && !out_ready)
                      || (overrun_q && !clr_overrun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign integ     = integ_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

`ifdef DELTA_DEMOD_OVLD_EN
    logic [7:0] run_q, run_d;
    logic       last_bit_q, last_bit_d;

    // A zero run count means no bit seen yet, so the next bit starts a fresh run.
    always_comb begin
        run_d      = run_q;
        last_bit_d = last_bit_q;
        if (bit_en) begin
            last_bit_d = bit_in;
            if (run_q == 8'd0 || bit_in != last_bit_q)
                run_d = 8'd1;
            else if (run_q != 8'hFF)
                run_d = run_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q      <= '0;
            last_bit_q <= 1'b0;
        end else begin
            run_q      <= run_d;
            last_bit_q <= last_bit_d;
        end
    end

    assign ovld = (run_q >= 8'(OVLD_LEN));
`else
    assign ovld = 1'b0;
`endif

endmodule

// File: doc/delta_demod.md
Name: delta_demod

Overview:
Receive-side counterpart of the delta-modulator counter. Consumes the 1-bit delta stream (1 = step up, 0 = step down) and rebuilds the staircase with an identical saturating 8-bit integrator. A boxcar average over 2^LOG2_DEC steps smooths and decimates the staircase into PCM samples. Samples leave through a valid/ready handshake toward the DAC/FIFO side.

Parameters:
LOG2_DEC, 2, log2 of decimation ratio (1..6); N = 2^LOG2_DEC steps per output sample
OVLD_LEN, 8, run length of identical bits that flags slope overload (optional feature only; 2..255)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
bit_in  in  1  delta stream bit; sampled only when bit_en=1
bit_en  in  1  one-cycle strobe, one per delta step; may be held high for back-to-back steps
out_data  out  8  decimated reconstructed sample
out_valid  out  1  out_data holds an unconsumed sample
out_ready  in  1  consumer accepts when out_valid & out_ready at posedge
integ  out  8  current integrator (staircase) value, for monitoring
overrun  out  1  sticky: a sample was overwritten before being consumed
clr_overrun  in  1  synchronous clear of overrun
ovld  out  1  slope-overload flag (optional feature; tied 0 when compiled out)

Behaviour:
- Reset (async, rst=1): integ=0, accumulator=0, step count=0, out_data=0, out_valid=0, overrun=0, ovld=0, run counter=0. Release is synchronous-safe; first step accepted on the first edge with bit_en=1 after rst falls.
- Integrator, on edge with bit_en=1: bit_in=1 -> integ+1 unless integ==255 (hold); bit_in=0 -> integ-1 unless integ==0 (hold). bit_en=0 -> integ holds. Must track the encoder counter bit-exactly.
- Accumulator width 8+LOG2_DEC, never overflows. On each step: acc += integ_next (post-update value). Step count 0..N-1.
- When a step arrives with count==N-1: out_data <= (acc + integ_next) >> LOG2_DEC (truncate), acc <= 0, count <= 0, out_valid <= 1. Latency: out_valid high on the edge of the Nth step; visible the following cycle.
- Handshake: out_valid & out_ready at edge -> sample consumed; out_valid falls next cycle unless a new sample completes on the same edge.
- Simultaneous consume + new sample: out_valid stays 1, out_data takes the new value, no overrun.
- New sample while out_valid=1 and out_ready=0: out_data overwritten with the new value, out_valid stays 1, overrun <= 1.
- overrun clears only on clr_overrun=1 (or rst). If set and clear occur on the same edge, set wins.
- out_data stable while out_valid=1 and no new sample completes.
- Reset mid-frame discards the partial accumulation and any pending sample.

Optional Feature:
Macro DELTA_DEMOD_OVLD_EN.
- Defined: 8-bit run counter counts consecutive identical bits on bit_en steps (first bit after reset or a change = run 1). ovld=1 while run >= OVLD_LEN. A differing bit drops ovld on that same edge. Counter saturates at 255.
- Undefined: no run counter, ovld constant 0.

Test Plan:
- LOG2_DEC=2, reset, 4 steps of 1 -> integ 1,2,3,4; sum 10 -> out_data=2, out_valid=1; out_ready=1 -> out_valid=0 next cycle.
- 300 consecutive 1 steps -> integ saturates at 255 and holds; later samples out_data=255. Then 300 zeros -> integ floors at 0; out_data=0, no wrap.
- From reset, alternating 1,0,1,0 -> integ 1,0,1,0, out_data=0. Zeros at integ=0 -> integ stays 0.
- out_ready=0 across 2 sample completions -> out_data = second sample, overrun=1. clr_overrun -> overrun=0. Consume + completion on the same edge -> out_valid stays 1, overrun unchanged.
- Assert rst after 2 of 4 steps, release, send 4 ones -> out_data=2 (partial sum discarded); rst pulse while out_valid=1 -> out_valid=0 immediately (async).
- With DELTA_DEMOD_OVLD_EN, OVLD_LEN=8: 7 ones -> ovld=0; 8th -> ovld=1; a 0 -> ovld=0. Without the macro, ovld=0 throughout.
